// File: rtl/orientation_sampler.sv
// Measurement sequencer feeding orientation_math: averages a burst of fixes at the
// original spot, moves the rover one step, settles, averages a final burst, then runs the calculation.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for start after reset
// ORIG_REQ   | request one fix at the original spot
// ORIG_WAIT  | waiting for that fix (timed)
// MOVE       | command one forward step
// MOVE_WAIT  | waiting for the rover to finish moving (timed)
// SETTLE     | let the rover come to rest before the final burst
// FINAL_REQ  | request one fix at the final spot
// FINAL_WAIT | waiting for that fix (timed)
// CHECK      | reject a zero-movement pair, else kick orientation_math
// CALC_WAIT  | waiting for orientation_math done (timed)
// DONE       | result valid, ready for the next start
// ERROR      | cycle failed, ready for the next start
module orientation_sampler #(
  parameter int LOG2_SAMPLES   = 2,
  parameter int SETTLE_CYCLES  = 27000000,
  parameter int TIMEOUT_CYCLES = 54000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        meas_req,
  input  logic        meas_valid,
  input  logic [11:0] meas_r_theta,
  output logic        move_cmd,
  input  logic        move_done,
  output logic [11:0] r_theta_original,
  output logic [11:0] r_theta_final,
  output logic        orient_enable,
  input  logic        orient_done,
  input  logic [4:0]  orient_value,
  output logic [4:0]  orientation,
  output logic        orientation_valid,
  output logic        busy,
  output logic        error
);

  localparam int SW   = 8 + LOG2_SAMPLES;
  localparam int CW   = LOG2_SAMPLES + 1;
  localparam int TMAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] SET_LOAD = TW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] LAST     = CW'((1 << LOG2_SAMPLES) - 1);

  typedef enum logic [3:0] {
    IDLE, ORIG_REQ, ORIG_WAIT, MOVE, MOVE_WAIT, SETTLE,
    FINAL_REQ, FINAL_WAIT, CHECK, CALC_WAIT, DONE, ERROR
  } state_t;

  state_t        state, state_next;
  logic [SW-1:0] sum, sum_add, sum_shr;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmr;
  logic [7:0]    r_avg;
  logic          burst_last, idle_like, start_ok, tmr_zero, fix_in;

  assign sum_add    = sum + SW'(meas_r_theta[7:0]);
  assign sum_shr    = sum_add >> LOG2_SAMPLES;
  assign r_avg      = sum_shr[7:0];
  assign burst_last = (cnt == LAST);
  assign idle_like  = (state == IDLE) || (state == DONE) || (state == ERROR);
  assign start_ok   = idle_like && start;
  assign tmr_zero   = (tmr == '0);
  assign fix_in     = meas_valid && ((state == ORIG_WAIT) || (state == FINAL_WAIT));

  assign busy              = !idle_like;
  assign error             = (state == ERROR);
  assign orientation_valid = (state == DONE);

  always_comb begin
    state_next    = state;
    meas_req      = 1'b0;
    move_cmd      = 1'b0;
    orient_enable = 1'b0;
    case (state)
      IDLE, DONE, ERROR: if (start) state_next = ORIG_REQ;
      ORIG_REQ: begin
        meas_req   = 1'b1;
        state_next = ORIG_WAIT;
      end
      ORIG_WAIT: begin
        if (meas_valid)    state_next = burst_last ? MOVE : ORIG_REQ;
        else if (tmr_zero) state_next = ERROR;
      end
      MOVE: begin
        move_cmd   = 1'b1;
        state_next = MOVE_WAIT;
      end
      // A zero settle time skips SETTLE entirely rather than spending one cycle there.
      MOVE_WAIT: begin
        if (move_done)     state_next = (SETTLE_CYCLES == 0) ? FINAL_REQ : SETTLE;
        else if (tmr_zero) state_next = ERROR;
      end
      SETTLE: if (tmr_zero) state_next = FINAL_REQ;
      FINAL_REQ: begin
        meas_req   = 1'b1;
        state_next = FINAL_WAIT;
      end
      FINAL_WAIT: begin
        if (meas_valid)    state_next = burst_last ? CHECK : FINAL_REQ;
        else if (tmr_zero) state_next = ERROR;
      end
      CHECK: begin
        if (r_theta_final == r_theta_original) begin
          state_next = ERROR;
        end else begin
          orient_enable = 1'b1;
          state_next    = CALC_WAIT;
        end
      end
      CALC_WAIT: begin
        if (orient_done)   state_next = DONE;
        else if (tmr_zero) state_next = ERROR;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= IDLE;
      sum              <= '0;
      cnt              <= '0;
      tmr              <= '0;
      r_theta_original <= '0;
      r_theta_final    <= '0;
      orientation      <= '0;
    end else begin
      state <= state_next;
      // One shared down-counter: timeout budget in wait states, settle time in SETTLE.
      if (state_next != state) begin
        case (state_next)
          ORIG_WAIT, MOVE_WAIT, FINAL_WAIT, CALC_WAIT: tmr <= TO_LOAD;
          SETTLE:                                      tmr <= SET_LOAD;
          default:                                     tmr <= '0;
        endcase
      end else if (!tmr_zero) begin
        tmr <= tmr - TW'(1);
      end
      if (start_ok) begin
        sum <= '0;
        cnt <= '0;
      end else if (fix_in) begin
        if (burst_last) begin
          sum <= '0;
          cnt <= '0;
          if (state == ORIG_WAIT) r_theta_original <= {meas_r_theta[11:8], r_avg};
          else                    r_theta_final    <= {meas_r_theta[11:8], r_avg};
        end else begin
          sum <= sum_add;
          cnt <= cnt + CW'(1);
        end
      end
      if ((state == CALC_WAIT) && orient_done) orientation <= orient_value;
    end
  end

endmodule

// File: tb/tb_orientation_sampler.sv
// Directed bench for orientation_sampler: nominal, zero move, timeout, start spam,
// reset mid-settle and stray handshake pulses, with hand-computed expectations.
module tb_orientation_sampler;

  logic        clk = 1'b0;
  logic        rst_n, start, meas_valid, move_done, orient_done;
  logic [11:0] meas_r_theta;
  logic [4:0]  orient_value;
  logic        meas_req, move_cmd, orient_enable, orientation_valid, busy, error;
  logic [11:0] r_theta_original, r_theta_final;
  logic [4:0]  orientation;

  int checks = 0;
  int errors = 0;
  int n_move = 0;
  int n_en   = 0;
  int m0, e0;

  orientation_sampler #(
    .LOG2_SAMPLES(2), .SETTLE_CYCLES(5), .TIMEOUT_CYCLES(100)
  ) dut (
    .clock(clk), .reset(rst_n), .start(start),
    .meas_req(meas_req), .meas_valid(meas_valid), .meas_r_theta(meas_r_theta),
    .move_cmd(move_cmd), .move_done(move_done),
    .r_theta_original(r_theta_original), .r_theta_final(r_theta_final),
    .orient_enable(orient_enable), .orient_done(orient_done), .orient_value(orient_value),
    .orientation(orientation), .orientation_valid(orientation_valid),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (move_cmd)      n_move++;
    if (orient_enable) n_en++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return meas_req;
      1:       return move_cmd;
      default: return orient_enable;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int w);
    int t = 0;
    while (!sel(w) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(sel(w)), 32'd1);
  endtask

  task automatic fix(input logic [11:0] v);
    wait_for("meas_req_seen", 0);
    @(negedge clk);
    meas_valid   = 1'b1;
    meas_r_theta = v;
    @(negedge clk);
    meas_valid   = 1'b0;
  endtask

  task automatic burst(input logic [11:0] a, input logic [11:0] b,
                       input logic [11:0] c, input logic [11:0] d);
    fix(a); fix(b); fix(c); fix(d);
  endtask

  task automatic move_step();
    wait_for("move_cmd_seen", 1);
    @(negedge clk);
    move_done = 1'b1;
    @(negedge clk);
    move_done = 1'b0;
  endtask

  task automatic finish_calc(input logic [4:0] v);
    wait_for("orient_enable_seen", 2);
    @(negedge clk);
    orient_done  = 1'b1;
    orient_value = v;
    @(negedge clk);
    orient_done  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_valid"}, 32'(orientation_valid), 32'd0);
    chk({tag, "_orient"}, 32'(orientation), 32'd0);
    chk({tag, "_rt_orig"}, 32'(r_theta_original), 32'd0);
    chk({tag, "_rt_final"}, 32'(r_theta_final), 32'd0);
    chk({tag, "_outs"}, 32'({meas_req, move_cmd, orient_enable}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; meas_valid = 1'b0; move_done = 1'b0;
    orient_done = 1'b0; meas_r_theta = '0; orient_value = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal run
    m0 = n_move; e0 = n_en;
    pulse_start();
    chk("nom_busy", 32'(busy), 32'd1);
    burst(12'h364, 12'h366, 12'h365, 12'h365);
    move_step();
    chk("nom_rt_orig", 32'(r_theta_original), 32'h365);
    burst(12'h478, 12'h478, 12'h478, 12'h478);
    finish_calc(5'd6);
    chk("nom_rt_final", 32'(r_theta_final), 32'h478);
    chk("nom_orient", 32'(orientation), 32'd6);
    chk("nom_valid", 32'(orientation_valid), 32'd1);
    chk("nom_busy_done", 32'(busy), 32'd0);
    chk("nom_error", 32'(error), 32'd0);
    chk("nom_moves", 32'(n_move - m0), 32'd1);
    chk("nom_enables", 32'(n_en - e0), 32'd1);

    // Zero movement
    e0 = n_en;
    pulse_start();
    chk("zm_valid_clr", 32'(orientation_valid), 32'd0);
    burst(12'h250, 12'h250, 12'h250, 12'h250);
    move_step();
    burst(12'h250, 12'h250, 12'h250, 12'h250);
    repeat (2) @(negedge clk);
    chk("zm_error", 32'(error), 32'd1);
    chk("zm_busy", 32'(busy), 32'd0);
    chk("zm_valid", 32'(orientation_valid), 32'd0);
    chk("zm_enables", 32'(n_en - e0), 32'd0);
    chk("zm_rt_final", 32'(r_theta_final), 32'h250);

    // Timeout in ORIG_WAIT
    pulse_start();
    chk("to_err_clr", 32'(error), 32'd0);
    chk("to_req", 32'(meas_req), 32'd1);
    @(negedge clk);
    repeat (99) @(negedge clk);
    chk("to_err_early", 32'(error), 32'd0);
    chk("to_busy_early", 32'(busy), 32'd1);
    @(negedge clk);
    chk("to_err", 32'(error), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);

    // Start held high throughout a nominal run
    m0 = n_move; e0 = n_en;
    start = 1'b1;
    @(negedge clk);
    burst(12'h364, 12'h366, 12'h365, 12'h365);
    move_step();
    burst(12'h478, 12'h478, 12'h478, 12'h478);
    finish_calc(5'd17);
    chk("spam_valid", 32'(orientation_valid), 32'd1);
    chk("spam_orient", 32'(orientation), 32'd17);
    chk("spam_moves", 32'(n_move - m0), 32'd1);
    chk("spam_enables", 32'(n_en - e0), 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk("spam_restart_busy", 32'(busy), 32'd1);
    chk("spam_restart_req", 32'(meas_req), 32'd1);
    chk("spam_restart_valid", 32'(orientation_valid), 32'd0);

    // Reset while settling
    burst(12'h123, 12'h125, 12'h121, 12'h123);
    move_step();
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_rt_orig", 32'(r_theta_original), 32'h123);
    rst_n = 1'b0;
    @(negedge clk);
    check_cleared("mid_reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Full run after reset, with stray handshakes injected
    m0 = n_move; e0 = n_en;
    pulse_start();
    burst(12'h364, 12'h366, 12'h365, 12'h365);
    wait_for("move_cmd_seen", 1);
    @(negedge clk);
    meas_valid   = 1'b1;
    meas_r_theta = 12'hFFF;
    @(negedge clk);
    meas_valid   = 1'b0;
    move_done    = 1'b1;
    @(negedge clk);
    move_done    = 1'b0;
    orient_done  = 1'b1;
    orient_value = 5'd9;
    @(negedge clk);
    orient_done  = 1'b0;
    chk("stray_busy", 32'(busy), 32'd1);
    chk("stray_orient", 32'(orientation), 32'd0);
    chk("stray_error", 32'(error), 32'd0);
    burst(12'h478, 12'h478, 12'h478, 12'h478);
    finish_calc(5'd6);
    chk("stray_rt_orig", 32'(r_theta_original), 32'h365);
    chk("stray_rt_final", 32'(r_theta_final), 32'h478);
    chk("stray_orient_done", 32'(orientation), 32'd6);
    chk("stray_valid", 32'(orientation_valid), 32'd1);
    chk("stray_moves", 32'(n_move - m0), 32'd1);
    chk("stray_enables", 32'(n_en - e0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
